vital_avg_alarm: RTL
====================

# vital_avg_alarm

Windowed averaging and alarm stage for one vital-sign channel. Accepts raw sensor samples with a valid strobe, averages each non-overlapping window of 2^LOG2N samples, and range-checks each average against programmable thresholds. A debounced alarm is driven from the range checks, with hysteresis. `avg_out`/`avg_valid` drive the `data_in`/`en` of the downstream holding register that latches the latest reading for display and logging.

## Interface
- `SIZE`, 8 — sample and average width (unsigned).
- `LOG2N`, 2 — log2 of window length; window N = 2^LOG2N samples.
- `ALARM_CNT`, 3 — consecutive out-of-range averages to raise alarm; also consecutive in-range averages to drop it. Must be ≥1.
- `clk` in 1 — single clock; all state changes on the rising edge.
- `rst` in 1 — reset, asynchronous, active-low.
- `sample_valid` in 1 — `sample_in` is valid this cycle.
- `sample_in` in SIZE — raw sample.
- `thr_low` in SIZE — lower bound, inclusive in-range.
- `thr_high` in SIZE — upper bound, inclusive in-range.
- `clear` in 1 — synchronous restart of window and alarm logic.
- `avg_out` out SIZE — last completed window average.
- `avg_valid` out 1 — one-cycle pulse when `avg_out` updates.
- `out_of_range` out 1 — range result for the current `avg_out`.
- `alarm` out 1 — debounced alarm.

## Operation
- Accumulator is SIZE+LOG2N bits wide, so it never overflows. The sample counter is LOG2N bits.
- Every cycle with `sample_valid`=1 and `clear`=0: the sample is added to the accumulator and the counter increments. Gaps in `sample_valid` are allowed and simply stall the window.
- When the accepted sample is the Nth of the window:
  - `avg_out` ← (acc + sample) >> LOG2N (truncation, no rounding).
  - `avg_valid` ← 1 for exactly one cycle.
  - Accumulator and counter clear on the same edge, so the next cycle's sample starts a new window with no dead cycle.
- `out_of_range` ← (avg < `thr_low`) OR (avg > `thr_high`), registered together with `avg_out`.
  - Equality with either threshold is in range.
  - If `thr_low` > `thr_high`, every average is out of range.
- Alarm FSM is evaluated only on window completion; otherwise it holds. It keeps a streak counter `k`. States:
  - NORMAL (`alarm`=0): out-of-range → PENDING, k=1, or directly ALARM if ALARM_CNT=1. In-range → stay.
  - PENDING (`alarm`=0): out-of-range → k+1; on reaching ALARM_CNT → ALARM. In-range → NORMAL, k=0.
  - ALARM (`alarm`=1): in-range → RECOVER, k=1, or directly NORMAL if ALARM_CNT=1. Out-of-range → stay.
  - RECOVER (`alarm`=1): in-range → k+1; on reaching ALARM_CNT → NORMAL. Out-of-range → ALARM, k=0.
- `clear`=1 has priority over `sample_valid`; a coincident sample is discarded. `clear` does the following:
  - Zeroes accumulator, counter and `k`.
  - Moves the FSM to NORMAL and forces `alarm`=0.
  - Forces `avg_valid`=0.
  - Holds `avg_out` and `out_of_range`.
- `rst` low, at any time including mid-window: all state and all outputs go to 0 immediately, and the FSM goes to NORMAL.

## Timing
- Reset values: `avg_out`=0, `avg_valid`=0, `out_of_range`=0, `alarm`=0.
- Latency:
  - Nth sample accepted at edge t → `avg_out`, `avg_valid`, `out_of_range` and `alarm` all update at edge t.
  - They are visible in the cycle following that edge.
  - The downstream register captures `avg_out` on edge t+1.
- Throughput: one sample per cycle; one average every N accepted samples.
- `avg_valid` is never high two cycles in a row unless N=1 (LOG2N=0) with back-to-back samples.
- Thresholds are sampled only on the completion edge; changing them mid-window is legal.

## Test plan
SIZE=8, LOG2N=2, ALARM_CNT=3, `thr_low`=60, `thr_high`=100 unless stated.
- Reset: hold `rst` low, then release → all outputs 0; no `avg_valid` until 4 samples are accepted.
- Samples 70, 71, 72, 74 back-to-back → single `avg_valid` pulse the cycle after 74, `avg_out`=71, `out_of_range`=0. The same samples with idle gaps give the same result.
- Edge values:
  - Four samples of 255 → `avg_out`=255 (no overflow).
  - Windows averaging exactly 60 and exactly 100 → `out_of_range`=0.
  - Window averaging 101 → `out_of_range`=1.
- Alarm hysteresis:
  - Three windows averaging 120 → `alarm` rises with the third `avg_valid`.
  - Then in, in, out, in, in, in → `alarm` stays 1 until the final in-range average, then drops.
  - Sequence out, out, in, out, out → `alarm` never asserts.
- Clear:
  - After 2 samples of 200, pulse `clear`, with a `sample_valid`=1 sample of 200 in the same cycle.
  - Then feed 80 ×4 → `avg_out`=80; `alarm` forced 0 on `clear`.
- Mid-window reset: after 3 samples, pull `rst` low asynchronously (off clock edge) → outputs 0 at once. After release, 4 samples of 90 → `avg_out`=90.

Source files
------------

// File: rtl/vital_avg_alarm_if.sv
// Sample/threshold/result bundle for one vital-sign averaging channel.
interface vital_avg_alarm_if #(
  parameter int unsigned SIZE = 8
);
  logic            sample_valid;
  logic [SIZE-1:0] sample_in;
  logic [SIZE-1:0] thr_low;
  logic [SIZE-1:0] thr_high;
  logic            clear;
  logic [SIZE-1:0] avg_out;
  logic            avg_valid;
  logic            out_of_range;
  logic            alarm;

  // Sensor/control side drives samples and thresholds, observes results.
  modport master (
    output sample_valid, sample_in, thr_low, thr_high, clear,
    input  avg_out, avg_valid, out_of_range, alarm
  );

  // Averaging stage consumes samples and produces results.
  modport slave (
    input  sample_valid, sample_in, thr_low, thr_high, clear,
    output avg_out, avg_valid, out_of_range, alarm
  );
endinterface

// File: rtl/vital_avg_alarm.sv
// Windowed averager with threshold check and debounced, hysteretic alarm.
module vital_avg_alarm #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned LOG2N     = 2,
  parameter int unsigned ALARM_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  vital_avg_alarm_if.slave  bus
);

  localparam int unsigned ACC_W = SIZE + LOG2N;
  localparam int unsigned CNT_W = (LOG2N > 0) ? LOG2N : 1;
  localparam int unsigned N     = 1 << LOG2N;
  localparam int unsigned K_W   = $clog2(ALARM_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [K_W-1:0]   K_FULL   = K_W'(ALARM_CNT);

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_ALARM   = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [1:0]       state_q, state_d;
  logic [SIZE-1:0]  avg_q, avg_d;
  logic             avg_valid_q, avg_valid_d;
  logic             oor_q, oor_d;
  logic             alarm_q, alarm_d;

  logic [ACC_W-1:0] sum_c;
  logic [SIZE-1:0]  avg_c;
  logic             oor_c;
  logic [K_W-1:0]   k_inc_c;

  // State register; async active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      state_q     <= ST_NORMAL;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      oor_q       <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      state_q     <= state_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      oor_q       <= oor_d;
      alarm_q     <= alarm_d;
    end
  end

  // Window accumulation, average/range result and alarm FSM step on completion.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    state_d     = state_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    oor_d       = oor_q;
    alarm_d     = alarm_q;

    sum_c   = acc_q + ACC_W'(bus.sample_in);
    avg_c   = SIZE'(sum_c >> LOG2N);
    oor_c   = (avg_c < bus.thr_low) || (avg_c > bus.thr_high);
    k_inc_c = K_W'(k_q + K_W'(1));

    if (bus.clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      k_d     = '0;
      state_d = ST_NORMAL;
      alarm_d = 1'b0;
    end else if (bus.sample_valid) begin
      if (cnt_q == CNT_LAST) begin
        acc_d       = '0;
        cnt_d       = '0;
        avg_d       = avg_c;
        avg_valid_d = 1'b1;
        oor_d       = oor_c;

        case (state_q)
          ST_NORMAL: begin
            if (oor_c) begin
              if (ALARM_CNT == 1) begin
                state_d = ST_ALARM;
                k_d     = '0;
              end else begin
                state_d = ST_PENDING;
                k_d     = K_W'(1);
              end
            end
          end
          ST_PENDING: begin
            if (oor_c) begin
              if (k_inc_c == K_FULL) begin
                state_d = ST_ALARM;
                k_d     = '0;
              end else begin
                k_d = k_inc_c;
              end
            end else begin
              state_d = ST_NORMAL;
              k_d     = '0;
            end
          end
          ST_ALARM: begin
            if (!oor_c) begin
              if (ALARM_CNT == 1) begin
                state_d = ST_NORMAL;
                k_d     = '0;
              end else begin
                state_d = ST_RECOVER;
                k_d     = K_W'(1);
              end
            end
          end
          default: begin
            if (!oor_c) begin
              if (k_inc_c == K_FULL) begin
                state_d = ST_NORMAL;
                k_d     = '0;
              end else begin
                k_d = k_inc_c;
              end
            end else begin
              state_d = ST_ALARM;
              k_d     = '0;
            end
          end
        endcase

        alarm_d = (state_d == ST_ALARM) || (state_d == ST_RECOVER);
      end else begin
        acc_d = sum_c;
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      end
    end
  end

  assign bus.avg_out      = avg_q;
  assign bus.avg_valid    = avg_valid_q;
  assign bus.out_of_range = oor_q;
  assign bus.alarm        = alarm_q;

endmodule
